accel_seq_ctrl: RTL and testbench

Parametrised sequencing control unit for the PE-array convolution accelerator. Latches a layer configuration word and programs the static array muxes. Runs a per-channel loop over C input channels: load weight rows, wait for inputs, compute, drain the MAC pipeline, write psums to output storage. Sits between the AXI-lite register file (params/start) and the PE array, weight buffer and output storage.

---
 rtl/accel_pkg.sv | 35 +++
 rtl/accel_pe_mask.sv | 21 ++
 rtl/accel_seq_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_accel_seq_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_pkg.sv
// Shared definitions for the convolution sequencing controller: FSM states,
// params_reg field layout and the layer-config legality check.
package accel_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CFG     = 3'd1,
        ST_LOAD_W  = 3'd2,
        ST_LOAD_I  = 3'd3,
        ST_COMPUTE = 3'd4,
        ST_DRAIN   = 3'd5,
        ST_WRITE   = 3'd6,
        ST_DONE    = 3'd7
    } state_e;

    // params_reg field layout
    localparam int FLD_W      = 4;
    localparam int R_LSB      = 0;
    localparam int S_LSB      = 4;
    localparam int U_LSB      = 8;
    localparam int TILE_LSB   = 12;
    localparam int C_LSB      = 16;
    localparam int C_FLD_W    = 12;
    localparam int VALID_BIT  = 30;
    localparam int SRST_BIT   = 31;

    // A layer is legal only if every dimension is non-zero and the kernel fits the array.
    function automatic logic cfg_ok(input logic [FLD_W-1:0] r, input logic [FLD_W-1:0] s,
                                    input logic [FLD_W-1:0] tile, input logic [C_FLD_W-1:0] c,
                                    input int pe_rows, input int pe_cols);
        return (r != '0) && (s != '0) && (tile != '0) && (c != '0) &&
               (int'(r) <= pe_rows) && (int'(s) <= pe_cols);
    endfunction

endpackage

// File: rtl/accel_pe_mask.sv
// Active-PE mask: bit r*PE_COLS+c is set when r < R and c < S.
module accel_pe_mask
    import accel_pkg::*;
#(
    parameter int PE_ROWS = 5,
    parameter int PE_COLS = 5
) (
    input  logic [FLD_W-1:0]           r_cnt,
    input  logic [FLD_W-1:0]           s_cnt,
    output logic [PE_ROWS*PE_COLS-1:0] mask
);

    for (genvar ri = 0; ri < PE_ROWS; ri++) begin : g_row
        for (genvar ci = 0; ci < PE_COLS; ci++) begin : g_col
            localparam logic [7:0] RI = 8'(ri);
            localparam logic [7:0] CI = 8'(ci);
            assign mask[ri*PE_COLS+ci] = (RI < {4'd0, r_cnt}) && (CI < {4'd0, s_cnt});
        end
    end

endmodule

// File: rtl/accel_seq_ctrl.sv
// Per-layer sequencer for the PE-array convolution accelerator: latches the
// layer config, programs the static muxes, then loops load-weights / load-inputs /
// compute / drain / write over C input channels.
module accel_seq_ctrl
    import accel_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int PE_ROWS        = 5,
    parameter int PE_COLS        = 5,
    parameter int MAC_PIPE_DEPTH = 2,
    parameter int ROW_SEL_W      = 4,
    parameter int C_W            = 12
) (
    input  logic                          CLK,
    input  logic                          RESETN,
    input  logic [DATA_WIDTH-1:0]         params_reg,
    input  logic                          start,
    input  logic                          weight_row_ack,
    input  logic                          inputs_ready,
    input  logic [PE_ROWS*PE_COLS-1:0]    mac_done,
    output logic [$clog2(PE_ROWS)-1:0]    weight_row_wr_ctrl,
    output logic                          weight_load_req,
    output logic                          input_load_req,
    output logic [PE_ROWS*PE_COLS-1:0]    add_mux_ctrl,
    output logic [PE_ROWS*PE_COLS-1:0]    stall_ctrl,
    output logic [PE_ROWS*PE_COLS-1:0]    resetn_mac_ctrl,
    output logic [ROW_SEL_W-1:0]          row_out_mux_ctrl,
    output logic [$clog2(PE_ROWS)-1:0]    psum_out_mux_ctrl,
    output logic                          out_storage_wr_en,
    output logic                          busy,
    output logic                          done,
    output logic                          cfg_err
);

    localparam int NPE = PE_ROWS * PE_COLS;
    localparam int RW  = $clog2(PE_ROWS);
    localparam int DW  = (MAC_PIPE_DEPTH > 1) ? $clog2(MAC_PIPE_DEPTH) : 1;

    // params_reg field extraction; U (stride) is not needed by the sequencer
    logic                soft_rst, cfg_valid;
    logic [FLD_W-1:0]    r_in, s_in, tile_in;
    logic [C_W-1:0]      c_in;
    logic                unused_params;
    assign soft_rst      = params_reg[SRST_BIT];
    assign cfg_valid     = params_reg[VALID_BIT];
    assign r_in          = params_reg[R_LSB +: FLD_W];
    assign s_in          = params_reg[S_LSB +: FLD_W];
    assign tile_in       = params_reg[TILE_LSB +: FLD_W];
    assign c_in          = params_reg[C_LSB +: C_W];
    assign unused_params = ^{params_reg[U_LSB +: FLD_W], params_reg[29:28]};

    state_e              state_q, state_d;
    logic [FLD_W-1:0]    r_q, r_d, s_q, s_d, tile_q, tile_d;
    logic [C_W-1:0]      c_q, c_d, ch_q, ch_d;
    logic [RW-1:0]       row_q, row_d;
    logic [DW-1:0]       drain_q, drain_d;
    logic                cfg_err_q, cfg_err_d;
    logic [NPE-1:0]      add_mux_q, add_mux_d;
    logic [ROW_SEL_W-1:0] row_out_q, row_out_d;
    logic [RW-1:0]       psum_out_q, psum_out_d;
    logic [NPE-1:0]      active_mask;

    accel_pe_mask #(.PE_ROWS(PE_ROWS), .PE_COLS(PE_COLS)) u_pe_mask (
        .r_cnt (r_q),
        .s_cnt (s_q),
        .mask  (active_mask)
    );

    // Next-state / datapath update; soft reset overrides everything except cfg_err and latched config
    always_comb begin
        state_d    = state_q;
        r_d        = r_q;
        s_d        = s_q;
        tile_d     = tile_q;
        c_d        = c_q;
        ch_d       = ch_q;
        row_d      = row_q;
        drain_d    = drain_q;
        cfg_err_d  = cfg_err_q;
        add_mux_d  = add_mux_q;
        row_out_d  = row_out_q;
        psum_out_d = psum_out_q;
        case (state_q)
            ST_IDLE: begin
                if (start && cfg_valid) begin
                    r_d    = r_in;
                    s_d    = s_in;
                    tile_d = tile_in;
                    c_d    = c_in;
                    if (cfg_ok(r_in, s_in, tile_in, c_in, PE_ROWS, PE_COLS)) begin
                        cfg_err_d = 1'b0;
                        state_d   = ST_CFG;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            ST_CFG: begin
                add_mux_d  = active_mask;
                row_out_d  = ROW_SEL_W'(tile_q - 4'd1);
                psum_out_d = RW'(r_q - 4'd1);
                ch_d       = '0;
                row_d      = '0;
                state_d    = ST_LOAD_W;
            end
            ST_LOAD_W: begin
                if (weight_row_ack) begin
                    if (32'(row_q) == 32'(r_q) - 1) begin
                        row_d   = '0;
                        state_d = ST_LOAD_I;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            ST_LOAD_I: begin
                if (inputs_ready) state_d = ST_COMPUTE;
            end
            ST_COMPUTE: begin
                // inactive PEs never report, so only the active bits gate the exit
                if ((mac_done & active_mask) == active_mask) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (32'(drain_q) == MAC_PIPE_DEPTH - 1) begin
                    drain_d = '0;
                    state_d = ST_WRITE;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            ST_WRITE: begin
                if (ch_q == c_q - 1'b1) begin
                    state_d = ST_DONE;
                end else begin
                    ch_d    = ch_q + 1'b1;
                    state_d = ST_LOAD_W;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (soft_rst) begin
            state_d    = ST_IDLE;
            r_d        = r_q;
            s_d        = s_q;
            tile_d     = tile_q;
            c_d        = c_q;
            ch_d       = '0;
            row_d      = '0;
            drain_d    = '0;
            cfg_err_d  = cfg_err_q;
            add_mux_d  = '0;
            row_out_d  = '0;
            psum_out_d = '0;
        end
    end

    // State and config registers, synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q    <= ST_IDLE;
            r_q        <= '0;
            s_q        <= '0;
            tile_q     <= '0;
            c_q        <= '0;
            ch_q       <= '0;
            row_q      <= '0;
            drain_q    <= '0;
            cfg_err_q  <= 1'b0;
            add_mux_q  <= '0;
            row_out_q  <= '0;
            psum_out_q <= '0;
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            s_q        <= s_d;
            tile_q     <= tile_d;
            c_q        <= c_d;
            ch_q       <= ch_d;
            row_q      <= row_d;
            drain_q    <= drain_d;
            cfg_err_q  <= cfg_err_d;
            add_mux_q  <= add_mux_d;
            row_out_q  <= row_out_d;
            psum_out_q <= psum_out_d;
        end
    end

    // Moore outputs decoded from the current state
    assign weight_row_wr_ctrl = row_q;
    assign weight_load_req    = (state_q == ST_LOAD_W);
    assign input_load_req     = (state_q == ST_LOAD_I);
    assign out_storage_wr_en  = (state_q == ST_WRITE);
    assign done               = (state_q == ST_DONE);
    assign busy               = (state_q != ST_IDLE);
    assign cfg_err            = cfg_err_q;
    assign add_mux_ctrl       = add_mux_q;
    assign row_out_mux_ctrl   = row_out_q;
    assign psum_out_mux_ctrl  = psum_out_q;
    assign stall_ctrl         = (state_q == ST_COMPUTE || state_q == ST_DRAIN) ? ~active_mask : '1;
    // accumulators held in clear while idle and during the CFG pulse
    assign resetn_mac_ctrl    = (state_q == ST_IDLE || state_q == ST_CFG) ? '0 : '1;

endmodule

// File: tb/tb_accel_seq_ctrl.sv
// Directed + randomized bench for accel_seq_ctrl against a cycle-level protocol model.
module tb_accel_seq_ctrl;

    localparam int DATA_WIDTH = 32, PE_ROWS = 5, PE_COLS = 5, MAC_PIPE_DEPTH = 2;
    localparam int ROW_SEL_W = 4, C_W = 12;
    localparam int NPE = PE_ROWS * PE_COLS;
    localparam int RW  = $clog2(PE_ROWS);

    logic                  CLK = 1'b0;
    logic                  RESETN = 1'b0;
    logic [DATA_WIDTH-1:0] params_reg = '0;
    logic                  start = 1'b0, weight_row_ack = 1'b0, inputs_ready = 1'b0;
    logic [NPE-1:0]        mac_done = '0;
    logic [RW-1:0]         weight_row_wr_ctrl, psum_out_mux_ctrl;
    logic                  weight_load_req, input_load_req, out_storage_wr_en, busy, done, cfg_err;
    logic [NPE-1:0]        add_mux_ctrl, stall_ctrl, resetn_mac_ctrl;
    logic [ROW_SEL_W-1:0]  row_out_mux_ctrl;

    int checks = 0, failures = 0;
    int n_wr = 0, n_done = 0, n_clr = 0;

    always #5 CLK = ~CLK;

    accel_seq_ctrl #(
        .DATA_WIDTH(DATA_WIDTH), .PE_ROWS(PE_ROWS), .PE_COLS(PE_COLS),
        .MAC_PIPE_DEPTH(MAC_PIPE_DEPTH), .ROW_SEL_W(ROW_SEL_W), .C_W(C_W)
    ) dut (
        .CLK(CLK), .RESETN(RESETN), .params_reg(params_reg), .start(start),
        .weight_row_ack(weight_row_ack), .inputs_ready(inputs_ready), .mac_done(mac_done),
        .weight_row_wr_ctrl(weight_row_wr_ctrl), .weight_load_req(weight_load_req),
        .input_load_req(input_load_req), .add_mux_ctrl(add_mux_ctrl), .stall_ctrl(stall_ctrl),
        .resetn_mac_ctrl(resetn_mac_ctrl), .row_out_mux_ctrl(row_out_mux_ctrl),
        .psum_out_mux_ctrl(psum_out_mux_ctrl), .out_storage_wr_en(out_storage_wr_en),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    // Event counters: write pulses, done pulses, busy cycles with accumulators held in clear
    always @(negedge CLK) begin
        if (RESETN) begin
            if (out_storage_wr_en) n_wr++;
            if (done) n_done++;
            if (busy && resetn_mac_ctrl != {NPE{1'b1}}) n_clr++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    // Active PEs from the layer rule r<R, c<S
    function automatic logic [NPE-1:0] exp_mask(input int r, input int s);
        logic [NPE-1:0] m = '0;
        for (int i = 0; i < PE_ROWS; i++)
            for (int j = 0; j < PE_COLS; j++)
                if (i < r && j < s) m[i*PE_COLS+j] = 1'b1;
        return m;
    endfunction

    function automatic logic [NPE-1:0] rand_vec();
        logic [63:0] v = {$urandom, $urandom};
        return v[NPE-1:0];
    endfunction

    function automatic logic [31:0] mk(input int r, input int s, input int tile, input int c,
                                       input bit vld, input bit srst);
        logic [31:0] p = '0;
        logic [31:0] u = $urandom;
        p[3:0]   = 4'(r);
        p[7:4]   = 4'(s);
        p[11:8]  = u[3:0];
        p[15:12] = 4'(tile);
        p[27:16] = 12'(c);
        p[30]    = vld;
        p[31]    = srst;
        return p;
    endfunction

    task automatic check_reset_outs(input string tag);
        logic [NPE-1:0] all1 = '1;
        chk({tag, "_wrow"}, weight_row_wr_ctrl, 0);
        chk({tag, "_wreq"}, weight_load_req, 0);
        chk({tag, "_ireq"}, input_load_req, 0);
        chk({tag, "_addmux"}, add_mux_ctrl, 0);
        chk({tag, "_stall"}, stall_ctrl, all1);
        chk({tag, "_macrst"}, resetn_mac_ctrl, 0);
        chk({tag, "_rowmux"}, row_out_mux_ctrl, 0);
        chk({tag, "_psummux"}, psum_out_mux_ctrl, 0);
        chk({tag, "_wren"}, out_storage_wr_en, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    // From IDLE: start a valid layer and advance to the first LOAD_W cycle
    task automatic begin_layer(input int r, input int s, input int tile, input int c);
        logic [NPE-1:0] m = exp_mask(r, s);
        params_reg = mk(r, s, tile, c, 1'b1, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        params_reg = $urandom & 32'h7FFF_FFFF;
        chk("cfg_busy", busy, 1);
        chk("cfg_macrst", resetn_mac_ctrl, 0);
        chk("cfg_err_clr", cfg_err, 0);
        step();
        chk("add_mux", add_mux_ctrl, m);
        chk("psum_mux", psum_out_mux_ctrl, r - 1);
        chk("row_mux", row_out_mux_ctrl, tile - 1);
    endtask

    task automatic load_weights(input int r, input bit fast);
        for (int row = 0; row < r; row++) begin
            int dly = fast ? 0 : $urandom_range(0, 2);
            for (int k = 0; k < dly; k++) begin
                chk("wrow_hold", weight_row_wr_ctrl, row);
                start = 1'($urandom_range(0, 1));
                params_reg = $urandom & 32'h7FFF_FFFF;
                step();
                start = 1'b0;
            end
            chk("wload_req", weight_load_req, 1);
            chk("wrow", weight_row_wr_ctrl, row);
            weight_row_ack = 1'b1;
            step();
            weight_row_ack = 1'b0;
        end
    endtask

    task automatic load_inputs(input bit fast);
        int dly = fast ? 0 : $urandom_range(0, 2);
        for (int k = 0; k < dly; k++) begin
            chk("iload_wait", input_load_req, 1);
            step();
        end
        chk("iload_req", input_load_req, 1);
        inputs_ready = 1'b1;
        step();
        inputs_ready = 1'b0;
    endtask

    task automatic run_layer(input int r, input int s, input int tile, input int c, input bit fast);
        logic [NPE-1:0] m = exp_mask(r, s);
        logic [NPE-1:0] nm = ~m;
        logic [NPE-1:0] all1 = '1;
        logic [NPE-1:0] v;
        n_wr = 0; n_done = 0; n_clr = 0;
        begin_layer(r, s, tile, c);
        for (int ch = 0; ch < c; ch++) begin
            load_weights(r, fast);
            load_inputs(fast);
            chk("stall_comp", stall_ctrl, nm);
            // incomplete done vectors must hold COMPUTE
            for (int j = 0; j < (fast ? 1 : $urandom_range(1, 3)); j++) begin
                int rr = $urandom_range(0, r - 1);
                int cc = $urandom_range(0, s - 1);
                v = rand_vec() | nm;
                v[rr*PE_COLS+cc] = 1'b0;
                mac_done = (j == 0) ? nm : v;
                step();
                chk("stay_stall", stall_ctrl, nm);
                chk("stay_wren", out_storage_wr_en, 0);
            end
            mac_done = m | rand_vec();
            for (int d = 0; d < MAC_PIPE_DEPTH; d++) begin
                step();
                mac_done = '0;
                chk("drain_stall", stall_ctrl, nm);
                chk("drain_wren", out_storage_wr_en, 0);
            end
            step();
            chk("wr_en", out_storage_wr_en, 1);
            chk("wr_stall", stall_ctrl, all1);
            step();
            if (ch == c - 1) begin
                chk("done", done, 1);
                step();
                chk("idle_busy", busy, 0);
                chk("idle_done", done, 0);
            end else begin
                chk("no_done", done, 0);
            end
        end
        step();
        chk("n_wr", n_wr, c);
        chk("n_done", n_done, 1);
        chk("n_clr", n_clr, 1);
        chk("mux_hold", add_mux_ctrl, m);
        chk("psum_hold", psum_out_mux_ctrl, r - 1);
    endtask

    initial begin
        logic [NPE-1:0] m;
        logic [NPE-1:0] nm;

        // reset values
        RESETN = 1'b0;
        repeat (3) step();
        check_reset_outs("rst");
        chk("rst_cfgerr", cfg_err, 0);
        RESETN = 1'b1;
        step();

        // directed layer from the plan, then a 3-channel layer
        run_layer(3, 3, 5, 1, 1'b0);
        run_layer(4, 5, 9, 3, 1'b0);

        // randomized legal layers
        for (int t = 0; t < 6; t++)
            run_layer($urandom_range(1, PE_ROWS), $urandom_range(1, PE_COLS),
                      $urandom_range(1, 15), $urandom_range(1, 4), 1'b0);

        // illegal configs set cfg_err and never leave IDLE
        for (int t = 0; t < 4; t++) begin
            case (t)
                0: params_reg = mk(6, 3, 3, 1, 1'b1, 1'b0);
                1: params_reg = mk(3, 0, 3, 1, 1'b1, 1'b0);
                2: params_reg = mk(3, 3, 0, 1, 1'b1, 1'b0);
                default: params_reg = mk(2, 6, 3, 0, 1'b1, 1'b0);
            endcase
            start = 1'b1;
            step();
            start = 1'b0;
            chk("bad_err", cfg_err, 1);
            chk("bad_busy", busy, 0);
            step();
            chk("bad_busy2", busy, 0);
        end

        // soft reset beats start and keeps cfg_err; start without valid is ignored
        params_reg = mk(2, 2, 2, 1, 1'b1, 1'b1);
        start = 1'b1;
        step();
        start = 1'b0;
        params_reg = '0;
        chk("srst_start_busy", busy, 0);
        chk("srst_keep_err", cfg_err, 1);
        params_reg = mk(2, 2, 2, 1, 1'b0, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("novalid_busy", busy, 0);
        chk("novalid_err", cfg_err, 1);

        // R=2,S=2: inactive-only done vector holds COMPUTE; valid start clears cfg_err
        run_layer(2, 2, 3, 1, 1'b0);

        // soft reset mid-COMPUTE
        n_done = 0;
        m = exp_mask(4, 3);
        nm = ~m;
        begin_layer(4, 3, 7, 2);
        load_weights(4, 1'b0);
        load_inputs(1'b0);
        chk("sr_comp_stall", stall_ctrl, nm);
        params_reg = mk(4, 3, 7, 2, 1'b0, 1'b1);
        step();
        params_reg = '0;
        check_reset_outs("srst");
        chk("srst_cfgerr", cfg_err, 0);
        repeat (4) step();
        chk("srst_busy_later", busy, 0);
        chk("srst_no_done", n_done, 0);

        // synchronous RESETN mid-LOAD_W
        begin_layer(3, 2, 4, 2);
        weight_row_ack = 1'b1;
        step();
        weight_row_ack = 1'b0;
        chk("mid_wrow", weight_row_wr_ctrl, 1);
        RESETN = 1'b0;
        step();
        check_reset_outs("hrst");
        chk("hrst_cfgerr", cfg_err, 0);
        RESETN = 1'b1;
        step();

        // full-range channel count
        run_layer(1, 1, 1, 4095, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
